etapa_ex: RTL and testbench

//  EX stage of the 5-stage MIPS pipeline: operand forwarding, ALU, destination-register select, iterative MULT/DIV unit with HI/LO.

---
 rtl/etapa_ex_pkg.sv | 54 +++++
 rtl/ex_muldiv.sv | 132 +++++++++++++
 rtl/etapa_ex.sv | 128 ++++++++++++
 tb/tb_etapa_ex.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/etapa_ex_pkg.sv
// Shared definitions for the EX stage: ALU op codes, forwarding selects,
// memory access widths and the mult/div FSM states.
package etapa_ex_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_NOR    = 5'd5,
        OP_SLT    = 5'd6,
        OP_SLTU   = 5'd7,
        OP_SLL    = 5'd8,
        OP_SRL    = 5'd9,
        OP_SRA    = 5'd10,
        OP_LUI    = 5'd11,
        OP_MFHI   = 5'd12,
        OP_MFLO   = 5'd13,
        OP_PASS_B = 5'd14,
        OP_MULT   = 5'd15,
        OP_MULTU  = 5'd16,
        OP_DIV    = 5'd17,
        OP_DIVU   = 5'd18
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10,
        FWD_REG2 = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        BHW_BYTE = 2'b00,
        BHW_HALF = 2'b01,
        BHW_WORD = 2'b11
    } bhw_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(input alu_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_md(input alu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step
// per cycle on operand magnitudes, sign correction when HI/LO are written.
module ex_muldiv
    import etapa_ex_pkg::*;
#(
    parameter int unsigned MD_ITER = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_halt,
    input  logic [4:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_stall
);

    localparam int unsigned CW = $clog2(MD_ITER);

    md_state_e     state, state_next;
    alu_op_e       op;
    logic          start, a_neg, b_neg, last_step;
    logic [31:0]   a_mag, b_mag;
    logic [CW-1:0] count;
    logic [31:0]   acc_hi, acc_lo, operand_b;
    logic          is_div, neg_q, neg_r;
    logic [32:0]   mul_sum, div_shift;
    logic [31:0]   div_diff, step_hi, step_lo;
    logic [63:0]   prod;

    assign op        = alu_op_e'(i_op);
    assign start     = is_muldiv(op);
    assign a_neg     = is_signed_md(op) & i_a[31];
    assign b_neg     = is_signed_md(op) & i_b[31];
    assign a_mag     = a_neg ? -i_a : i_a;
    assign b_mag     = b_neg ? -i_b : i_b;
    assign last_step = (count == CW'(MD_ITER - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= MD_IDLE;
        else if (!i_halt)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        o_stall    = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    o_stall    = !i_halt;
                    state_next = MD_BUSY;
                end
            end
            MD_BUSY: begin
                o_stall = 1'b1;
                if (last_step)
                    state_next = MD_DONE;
            end
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // acc_hi holds the partial product high word / running remainder,
    // acc_lo the multiplier being consumed / quotient being built.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : 33'd0);
        div_shift = {acc_hi, acc_lo[31]};
        div_diff  = div_shift[31:0] - operand_b;
        if (is_div) begin
            if (div_shift >= {1'b0, operand_b}) begin
                step_hi = div_diff;
                step_lo = {acc_lo[30:0], 1'b1};
            end else begin
                step_hi = div_shift[31:0];
                step_lo = {acc_lo[30:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], acc_lo[31:1]};
        end
        prod = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            operand_b <= '0;
            is_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            o_hi      <= '0;
            o_lo      <= '0;
        end else if (!i_halt) begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        count     <= '0;
                        acc_hi    <= '0;
                        acc_lo    <= a_mag;
                        operand_b <= b_mag;
                        is_div    <= (op == OP_DIV) || (op == OP_DIVU);
                        // divide by zero keeps the all-ones quotient unsigned
                        neg_q     <= (a_neg ^ b_neg) & (|i_b);
                        neg_r     <= a_neg;
                    end
                end
                MD_BUSY: begin
                    count  <= count + 1'b1;
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    if (last_step) begin
                        if (is_div) begin
                            o_lo <= neg_q ? -step_lo : step_lo;
                            o_hi <= neg_r ? -step_hi : step_hi;
                        end else begin
                            o_hi <= prod[63:32];
                            o_lo <= prod[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/etapa_ex.sv
// MIPS EX stage: operand forwarding, ALU, destination select, mult/div unit
// and the EX/MEM pipeline register.
module etapa_ex
    import etapa_ex_pkg::*;
#(
    parameter int unsigned MD_ITER = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_halt,
    input  logic [31:0] i_read_data_1,
    input  logic [31:0] i_read_data_2,
    input  logic [31:0] i_immediate,
    input  logic [4:0]  i_shamt,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [1:0]  i_fwd_a,
    input  logic [1:0]  i_fwd_b,
    input  logic [31:0] i_MEM_fwd_data,
    input  logic [31:0] i_WB_fwd_data,
    input  logic [4:0]  i_EX_alu_op,
    input  logic        i_EX_alu_src,
    input  logic        i_EX_reg_dst,
    input  logic        i_EX_shift_var,
    input  logic        i_WB_write,
    input  logic        i_WB_mem_to_reg,
    input  logic        i_MEM_read,
    input  logic        i_MEM_write,
    input  logic        i_MEM_unsigned,
    input  logic [1:0]  i_MEM_byte_half_word,
    output logic        o_stall,
    output logic [31:0] o_ALU_result,
    output logic [31:0] o_data_to_write_in_MEM,
    output logic [4:0]  o_write_reg,
    output logic        o_WB_write,
    output logic        o_WB_mem_to_reg,
    output logic        o_MEM_read,
    output logic        o_MEM_write,
    output logic        o_MEM_unsigned,
    output logic [1:0]  o_MEM_byte_half_word
);

    alu_op_e     op;
    logic [31:0] op_a, rt_fwd, op_b, alu_result, hi, lo;
    logic [4:0]  sh;
    logic        bubble;

    assign op = alu_op_e'(i_EX_alu_op);

    always_comb begin
        case (fwd_sel_e'(i_fwd_a))
            FWD_MEM: op_a = i_MEM_fwd_data;
            FWD_WB:  op_a = i_WB_fwd_data;
            default: op_a = i_read_data_1;
        endcase
        case (fwd_sel_e'(i_fwd_b))
            FWD_MEM: rt_fwd = i_MEM_fwd_data;
            FWD_WB:  rt_fwd = i_WB_fwd_data;
            default: rt_fwd = i_read_data_2;
        endcase
        op_b = i_EX_alu_src ? i_immediate : rt_fwd;
        sh   = i_EX_shift_var ? op_a[4:0] : i_shamt;
    end

    always_comb begin
        alu_result = '0;
        case (op)
            OP_ADD:    alu_result = op_a + op_b;
            OP_SUB:    alu_result = op_a - op_b;
            OP_AND:    alu_result = op_a & op_b;
            OP_OR:     alu_result = op_a | op_b;
            OP_XOR:    alu_result = op_a ^ op_b;
            OP_NOR:    alu_result = ~(op_a | op_b);
            OP_SLT:    alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
            OP_SLTU:   alu_result = {31'b0, op_a < op_b};
            OP_SLL:    alu_result = op_b << sh;
            OP_SRL:    alu_result = op_b >> sh;
            OP_SRA:    alu_result = $signed(op_b) >>> sh;
            OP_LUI:    alu_result = op_b << 16;
            OP_MFHI:   alu_result = hi;
            OP_MFLO:   alu_result = lo;
            OP_PASS_B: alu_result = op_b;
            default:   alu_result = '0;
        endcase
    end

    ex_muldiv #(
        .MD_ITER(MD_ITER)
    ) u_muldiv (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_halt (i_halt),
        .i_op   (i_EX_alu_op),
        .i_a    (op_a),
        .i_b    (rt_fwd),
        .o_hi   (hi),
        .o_lo   (lo),
        .o_stall(o_stall)
    );

    // mult/div instructions never write a GPR, so they retire as bubbles too
    assign bubble = o_stall | is_muldiv(op);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ALU_result           <= '0;
            o_data_to_write_in_MEM <= '0;
            o_write_reg            <= '0;
            o_WB_write             <= 1'b0;
            o_WB_mem_to_reg        <= 1'b0;
            o_MEM_read             <= 1'b0;
            o_MEM_write            <= 1'b0;
            o_MEM_unsigned         <= 1'b0;
            o_MEM_byte_half_word   <= '0;
        end else if (!i_halt) begin
            o_ALU_result           <= alu_result;
            o_data_to_write_in_MEM <= rt_fwd;
            o_write_reg            <= i_EX_reg_dst ? i_rd : i_rt;
            o_WB_write             <= i_WB_write & !bubble;
            o_WB_mem_to_reg        <= i_WB_mem_to_reg;
            o_MEM_read             <= i_MEM_read & !bubble;
            o_MEM_write            <= i_MEM_write & !bubble;
            o_MEM_unsigned         <= i_MEM_unsigned;
            o_MEM_byte_half_word   <= i_MEM_byte_half_word;
        end
    end

endmodule

// File: tb/tb_etapa_ex.sv
// Directed self-checking bench for etapa_ex: ALU/forwarding vectors,
// mult/div timing and results, halt freeze and mid-operation reset.
module tb_etapa_ex;
    import etapa_ex_pkg::*;

    logic        i_clk, i_reset, i_halt;
    logic [31:0] i_read_data_1, i_read_data_2, i_immediate;
    logic [4:0]  i_shamt, i_rt, i_rd;
    logic [1:0]  i_fwd_a, i_fwd_b;
    logic [31:0] i_MEM_fwd_data, i_WB_fwd_data;
    logic [4:0]  i_EX_alu_op;
    logic        i_EX_alu_src, i_EX_reg_dst, i_EX_shift_var;
    logic        i_WB_write, i_WB_mem_to_reg, i_MEM_read, i_MEM_write, i_MEM_unsigned;
    logic [1:0]  i_MEM_byte_half_word;
    logic        o_stall;
    logic [31:0] o_ALU_result, o_data_to_write_in_MEM;
    logic [4:0]  o_write_reg;
    logic        o_WB_write, o_WB_mem_to_reg, o_MEM_read, o_MEM_write, o_MEM_unsigned;
    logic [1:0]  o_MEM_byte_half_word;

    int checks = 0;
    int errors = 0;

    etapa_ex #(
        .MD_ITER(32)
    ) dut (
        .i_clk                 (i_clk),
        .i_reset               (i_reset),
        .i_halt                (i_halt),
        .i_read_data_1         (i_read_data_1),
        .i_read_data_2         (i_read_data_2),
        .i_immediate           (i_immediate),
        .i_shamt               (i_shamt),
        .i_rt                  (i_rt),
        .i_rd                  (i_rd),
        .i_fwd_a               (i_fwd_a),
        .i_fwd_b               (i_fwd_b),
        .i_MEM_fwd_data        (i_MEM_fwd_data),
        .i_WB_fwd_data         (i_WB_fwd_data),
        .i_EX_alu_op           (i_EX_alu_op),
        .i_EX_alu_src          (i_EX_alu_src),
        .i_EX_reg_dst          (i_EX_reg_dst),
        .i_EX_shift_var        (i_EX_shift_var),
        .i_WB_write            (i_WB_write),
        .i_WB_mem_to_reg       (i_WB_mem_to_reg),
        .i_MEM_read            (i_MEM_read),
        .i_MEM_write           (i_MEM_write),
        .i_MEM_unsigned        (i_MEM_unsigned),
        .i_MEM_byte_half_word  (i_MEM_byte_half_word),
        .o_stall               (o_stall),
        .o_ALU_result          (o_ALU_result),
        .o_data_to_write_in_MEM(o_data_to_write_in_MEM),
        .o_write_reg           (o_write_reg),
        .o_WB_write            (o_WB_write),
        .o_WB_mem_to_reg       (o_WB_mem_to_reg),
        .o_MEM_read            (o_MEM_read),
        .o_MEM_write           (o_MEM_write),
        .o_MEM_unsigned        (o_MEM_unsigned),
        .o_MEM_byte_half_word  (o_MEM_byte_half_word)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_in();
        i_halt = 0; i_read_data_1 = '0; i_read_data_2 = '0; i_immediate = '0;
        i_shamt = '0; i_rt = '0; i_rd = '0; i_fwd_a = 2'b00; i_fwd_b = 2'b00;
        i_MEM_fwd_data = '0; i_WB_fwd_data = '0; i_EX_alu_op = OP_ADD;
        i_EX_alu_src = 0; i_EX_reg_dst = 0; i_EX_shift_var = 0;
        i_WB_write = 0; i_WB_mem_to_reg = 0; i_MEM_read = 0; i_MEM_write = 0;
        i_MEM_unsigned = 0; i_MEM_byte_half_word = 2'b00;
    endtask

    task automatic alu(input string tag, input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic src, input logic [4:0] shamt, input logic shv, input logic [31:0] exp);
        idle_in();
        i_EX_alu_op = op; i_read_data_1 = a; i_read_data_2 = b; i_immediate = b;
        i_EX_alu_src = src; i_shamt = shamt; i_EX_shift_var = shv;
        tick();
        chk(tag, o_ALU_result, exp);
    endtask

    task automatic md_run(input string tag, input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input int halt_at, input int halt_len, input int exp_stall,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        int bub;
        idle_in();
        i_EX_alu_op = op; i_read_data_1 = a; i_read_data_2 = b;
        i_WB_write = 1; i_MEM_write = 1; i_MEM_read = 1;
        #1;
        n = 0;
        bub = 0;
        while (o_stall === 1'b1 && n < 200) begin
            i_halt = (halt_at >= 0 && n >= halt_at && n < halt_at + halt_len);
            n++;
            tick();
            if (o_WB_write !== 1'b0 || o_MEM_write !== 1'b0 || o_MEM_read !== 1'b0) bub++;
        end
        i_halt = 0;
        chk({tag, "_stall_cycles"}, n, exp_stall);
        chk({tag, "_bubbles"}, bub, 0);
        tick();
        chk({tag, "_retire_bubble"}, {29'b0, o_WB_write, o_MEM_read, o_MEM_write}, 0);
        idle_in();
        i_EX_alu_op = OP_MFLO; i_WB_write = 1; i_EX_reg_dst = 1; i_rd = 5'd8;
        tick();
        chk({tag, "_lo"}, o_ALU_result, exp_lo);
        i_EX_alu_op = OP_MFHI;
        tick();
        chk({tag, "_hi"}, o_ALU_result, exp_hi);
    endtask

    initial begin
        int n;
        idle_in();
        i_reset = 1;
        tick();
        tick();
        chk("rst_alu", o_ALU_result, 0);
        chk("rst_wreg", {27'b0, o_write_reg}, 0);
        chk("rst_ctrl", {25'b0, o_WB_write, o_WB_mem_to_reg, o_MEM_read, o_MEM_write,
                         o_MEM_unsigned, o_MEM_byte_half_word}, 0);
        chk("rst_stall", {31'b0, o_stall}, 0);
        i_reset = 0;

        // ADD with immediate, rd destination, controls passed through
        idle_in();
        i_EX_alu_op = OP_ADD; i_read_data_1 = 32'd7; i_immediate = 32'd5; i_EX_alu_src = 1;
        i_EX_reg_dst = 1; i_rd = 5'd3; i_rt = 5'd4;
        i_WB_write = 1; i_WB_mem_to_reg = 1; i_MEM_read = 1; i_MEM_write = 0;
        i_MEM_unsigned = 1; i_MEM_byte_half_word = 2'b01;
        tick();
        chk("add_result", o_ALU_result, 32'd12);
        chk("add_wreg", {27'b0, o_write_reg}, 32'd3);
        chk("add_ctrl", {25'b0, o_WB_write, o_WB_mem_to_reg, o_MEM_read, o_MEM_write,
                         o_MEM_unsigned, o_MEM_byte_half_word}, 32'b1110101);

        // SUB with both operands forwarded, rt destination
        idle_in();
        i_EX_alu_op = OP_SUB; i_fwd_a = 2'b01; i_MEM_fwd_data = 32'h10;
        i_fwd_b = 2'b10; i_WB_fwd_data = 32'h20;
        i_read_data_1 = 32'hDEAD_0001; i_read_data_2 = 32'hDEAD_0002;
        i_rt = 5'd7; i_rd = 5'd9; i_MEM_write = 1;
        tick();
        chk("sub_fwd_result", o_ALU_result, 32'hFFFF_FFF0);
        chk("sub_fwd_store", o_data_to_write_in_MEM, 32'h20);
        chk("sub_fwd_wreg", {27'b0, o_write_reg}, 32'd7);
        chk("sub_fwd_memw", {31'b0, o_MEM_write}, 32'd1);

        // fwd code 11 selects the register file
        idle_in();
        i_EX_alu_op = OP_PASS_B; i_fwd_b = 2'b11; i_read_data_2 = 32'h55AA_1234;
        i_MEM_fwd_data = 32'h1; i_WB_fwd_data = 32'h2;
        tick();
        chk("fwd11_pass", o_ALU_result, 32'h55AA_1234);

        alu("slt_neg",  OP_SLT,  32'hFFFF_FFFF, 32'd1, 1'b1, 5'd0, 1'b0, 32'd1);
        alu("sltu_neg", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd0, 1'b0, 32'd0);
        alu("sra_4",    OP_SRA,  32'd0, 32'h8000_0000, 1'b0, 5'd4, 1'b0, 32'hF800_0000);
        alu("srl_var",  OP_SRL,  32'd4, 32'h8000_0000, 1'b0, 5'd31, 1'b1, 32'h0800_0000);
        alu("sll_31",   OP_SLL,  32'd0, 32'd3, 1'b0, 5'd31, 1'b0, 32'h8000_0000);
        alu("lui",      OP_LUI,  32'd0, 32'h0000_1234, 1'b1, 5'd0, 1'b0, 32'h1234_0000);
        alu("nor_zero", OP_NOR,  32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'hFFFF_FFFF);
        alu("xor",      OP_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 5'd0, 1'b0, 32'hFF00_0FF0);
        alu("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'd2, 1'b0, 5'd0, 1'b0, 32'd1);

        md_run("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd5, -1, 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        md_run("divu_zero", OP_DIVU,  32'd100, 32'd0, -1, 0, 33, 32'd100, 32'hFFFF_FFFF);
        md_run("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2, -1, 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        md_run("div_edge",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 33, 32'd0, 32'h8000_0000);
        md_run("multu_halt", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 10, 5, 38, 32'd1, 32'd0);

        // reset while the divider is at count 10
        idle_in();
        i_EX_alu_op = OP_DIV; i_read_data_1 = 32'd100; i_read_data_2 = 32'd7;
        #1;
        n = 0;
        while (o_stall === 1'b1 && n < 11) begin
            n++;
            tick();
        end
        chk("rstmid_busy", {31'b0, o_stall}, 32'd1);
        i_reset = 1;
        i_EX_alu_op = OP_ADD;
        tick();
        chk("rstmid_stall", {31'b0, o_stall}, 0);
        chk("rstmid_store", o_data_to_write_in_MEM, 0);
        i_reset = 0;
        i_EX_alu_op = OP_MFLO;
        tick();
        chk("rstmid_lo", o_ALU_result, 0);
        i_EX_alu_op = OP_MFHI;
        tick();
        chk("rstmid_hi", o_ALU_result, 0);
        chk("rstmid_idle", {31'b0, o_stall}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
